// File: rtl/jk_counter_n.sv
// N-bit JK flip-flop state machine: hold / binary up / binary down / Gray up / load.
// Next state is chosen first; each bit then derives its J/K excitation from it.

module jk_ff (
   input  logic clk,
   input  logic j,
   input  logic k,
   output logic q
);
   logic r_q;

   // Characteristic equation only; reset reaches the flop as J=0, K=q.
   always_ff @(posedge clk)
      r_q <= (j & ~r_q) | (~k & r_q);

   assign q = r_q;
endmodule

module jk_counter_n #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             tc,
   output logic             wrap
);
   localparam logic [1:0] M_HOLD = 2'b00;
   localparam logic [1:0] M_UP   = 2'b01;
   localparam logic [1:0] M_DOWN = 2'b10;
   localparam logic [1:0] M_GRAY = 2'b11;
   localparam logic [WIDTH-1:0] GRAY_TOP = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;
   logic [WIDTH-1:0] w_gbin_inc;
   logic [WIDTH-1:0] w_gray_next;
   logic             w_step;
   logic             w_tc;
   logic             r_wrap;

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--)
         b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   // Current state is reinterpreted as Gray code, no conversion on mode switch.
   assign w_gbin_inc  = gray2bin(r_q) + WIDTH'(1);
   assign w_gray_next = w_gbin_inc ^ (w_gbin_inc >> 1);
   assign w_step      = en & ~load & ~reset;

   always_comb begin
      w_next = r_q;
      if (reset)
         w_next = '0;
      else if (load)
         w_next = d;
      else if (en) begin
         case (mode)
            M_UP:    w_next = r_q + WIDTH'(1);
            M_DOWN:  w_next = r_q - WIDTH'(1);
            M_GRAY:  w_next = w_gray_next;
            default: w_next = r_q;
         endcase
      end
   end

   always_comb begin
      w_tc = 1'b0;
      if (w_step) begin
         case (mode)
            M_UP:    w_tc = &r_q;
            M_DOWN:  w_tc = ~|r_q;
            M_GRAY:  w_tc = (r_q == GRAY_TOP);
            M_HOLD:  w_tc = 1'b0;
            default: w_tc = 1'b0;
         endcase
      end
   end

   // Don't-care excitation forced to 0.
   assign w_j = ~r_q & w_next;
   assign w_k = r_q & ~w_next;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ff
      jk_ff u_ff (
         .clk (clk),
         .j   (w_j[gi]),
         .k   (w_k[gi]),
         .q   (r_q[gi])
      );
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_wrap <= 1'b0;
      else
         r_wrap <= w_tc;
   end

   assign q    = r_q;
   assign j    = w_j;
   assign k    = w_k;
   assign tc   = w_tc;
   assign wrap = r_wrap;
endmodule
